hex_framer: RTL and testbench

HEX_FRAMER -- requirements
Module: hex_framer

---
 rtl/hex_framer.sv | 122 ++++++++++++
 tb/tb_hex_framer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_framer.sv
// Serialises 48-bit trace records into ASCII hex lines for a UART, with an
// optional '!' prefix flagging that the upstream ring buffer overflowed.
module hex_framer #(
   parameter int CRLF  = 1,
   parameter int UPPER = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [47:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        overflow,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, MARK, HEX, EOL_CR, EOL_LF} state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  nib_cnt;
   logic [3:0]  nib_cnt_next;
   logic [47:0] rec;
   logic        ovf_seen;
   logic        accept;
   logic [47:0] rec_shifted;
   logic [3:0]  nib;
   logic [7:0]  hex_char;

   assign in_ready = (state == IDLE) && !reset;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         nib_cnt  <= 4'd0;
         rec      <= 48'd0;
         ovf_seen <= 1'b0;
      end else begin
         state   <= state_next;
         nib_cnt <= nib_cnt_next;
         if (accept) begin
            rec <= in_data;
         end
         // Accept consumes the flag; an overflow seen later marks the next line.
         if (accept) begin
            ovf_seen <= 1'b0;
         end else if (overflow) begin
            ovf_seen <= 1'b1;
         end
      end
   end

   // Shifting the current nibble to the top avoids a variable part-select.
   assign rec_shifted = rec << {nib_cnt, 2'b00};
   assign nib         = rec_shifted[47:44];

   always_comb begin
      if (nib < 4'd10) begin
         hex_char = 8'h30 + {4'h0, nib};
      end else begin
         hex_char = ((UPPER != 0) ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_next   = state;
      nib_cnt_next = nib_cnt;
      out_valid    = 1'b1;
      out_data     = 8'h00;
      unique case (state)
         IDLE: begin
            out_valid = 1'b0;
            if (accept) begin
               nib_cnt_next = 4'd0;
               state_next   = (ovf_seen || overflow) ? MARK : HEX;
            end
         end
         MARK: begin
            out_data = 8'h21;
            if (out_ready) begin
               state_next = HEX;
            end
         end
         HEX: begin
            out_data = hex_char;
            if (out_ready) begin
               if (nib_cnt == 4'd11) begin
                  nib_cnt_next = 4'd0;
                  state_next   = (CRLF != 0) ? EOL_CR : EOL_LF;
               end else begin
                  nib_cnt_next = nib_cnt + 4'd1;
               end
            end
         end
         EOL_CR: begin
            out_data = 8'h0D;
            if (out_ready) begin
               state_next = EOL_LF;
            end
         end
         EOL_LF: begin
            out_data = 8'h0A;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            out_valid  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_hex_framer.sv
// Bench for hex_framer: one CRLF/upper-case instance and one LF/lower-case
// instance, each checked character-by-character against a scoreboard queue.
`timescale 1ns/1ps
module tb_hex_framer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic [47:0] a_in_data = '0;
   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic        a_overflow = 1'b0;
   logic [7:0]  a_out_data;
   logic        a_out_valid;
   logic        a_out_ready = 1'b1;
   logic        a_busy;
   logic        toggle = 1'b0;

   logic [47:0] b_in_data = '0;
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic        b_overflow = 1'b0;
   logic [7:0]  b_out_data;
   logic        b_out_valid;
   logic        b_out_ready = 1'b1;
   logic        b_busy;

   logic [7:0]  q0[$];
   logic [7:0]  q1[$];
   int          char_cyc0[$];
   logic        hold_v0 = 1'b0;
   logic        hold_v1 = 1'b0;
   logic [7:0]  hold_d0 = '0;
   logic [7:0]  hold_d1 = '0;
   logic [7:0]  e0;
   logic [7:0]  e1;

   hex_framer #(.CRLF(1), .UPPER(1)) dut_a (
      .clock(clock), .reset(reset),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .overflow(a_overflow),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .busy(a_busy)
   );

   hex_framer #(.CRLF(0), .UPPER(0)) dut_b (
      .clock(clock), .reset(reset),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .overflow(b_overflow),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .busy(b_busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      #1;
      a_out_ready = toggle ? ~a_out_ready : 1'b1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: a character completes on out_valid & out_ready.
   always @(negedge clock) begin
      if (reset) begin
         hold_v0 = 1'b0;
      end else begin
         if (hold_v0) check("stall_hold_a", a_out_data, hold_d0);
         hold_v0 = a_out_valid && !a_out_ready;
         hold_d0 = a_out_data;
         if (a_out_valid && a_out_ready) begin
            if (q0.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_a_unexpected actual=%0h required=none", a_out_data);
            end else begin
               e0 = q0.pop_front();
               check("char_a", a_out_data, e0);
               char_cyc0.push_back(cyc);
            end
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         hold_v1 = 1'b0;
      end else begin
         if (hold_v1) check("stall_hold_b", b_out_data, hold_d1);
         hold_v1 = b_out_valid && !b_out_ready;
         hold_d1 = b_out_data;
         if (b_out_valid && b_out_ready) begin
            if (q1.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_b_unexpected actual=%0h required=none", b_out_data);
            end else begin
               e1 = q1.pop_front();
               check("char_b", b_out_data, e1);
            end
         end
      end
   end

   task automatic push_line(input int sel, input logic [95:0] text, input bit mark, input int n);
      logic [7:0] ln[$];
      if (mark) ln.push_back(8'h21);
      for (int i = 0; i < 12; i++) ln.push_back(text[95-8*i -: 8]);
      if (sel == 0) ln.push_back(8'h0D);
      ln.push_back(8'h0A);
      for (int i = 0; i < n && i < ln.size(); i++) begin
         if (sel == 0) q0.push_back(ln[i]);
         else q1.push_back(ln[i]);
      end
   endtask

   // Called and returns at posedge+1.
   task automatic accept(input int sel, input logic [47:0] d, input bit keep_valid, output int acc_cyc);
      bit ok = 1'b0;
      acc_cyc = -1;
      if (sel == 0) begin a_in_data = d; a_in_valid = 1'b1; end
      else begin b_in_data = d; b_in_valid = 1'b1; end
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clock);
         if ((sel == 0) ? a_in_ready : b_in_ready) begin
            ok = 1'b1;
            acc_cyc = cyc;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=no_accept required=accept");
      end
      @(posedge clock);
      #1;
      if (!keep_valid) begin
         if (sel == 0) a_in_valid = 1'b0;
         else b_in_valid = 1'b0;
      end
   endtask

   task automatic drain(input int sel);
      bit ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(posedge clock);
         #1;
         if (sel == 0) ok = (q0.size() == 0) && !a_busy;
         else ok = (q1.size() == 0) && !b_busy;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=pending required=idle");
      end
   endtask

   task automatic pulse_ovf(input int sel);
      if (sel == 0) a_overflow = 1'b1;
      else b_overflow = 1'b1;
      @(posedge clock);
      #1;
      a_overflow = 1'b0;
      b_overflow = 1'b0;
   endtask

   typedef struct {
      int          sel;
      logic [47:0] data;
      bit          mark;
      logic [95:0] text;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int acc;
      int acc2;
      bit ok;

      vecs[0] = '{0, 48'h02_00000080_A5, 1'b0, "0200000080A5"};
      vecs[1] = '{0, 48'h00_0000FFFF_3C, 1'b1, "000000FFFF3C"};
      vecs[2] = '{0, 48'h00_0000FFFF_3C, 1'b0, "000000FFFF3C"};
      vecs[3] = '{0, 48'h9F_12345678_DE, 1'b0, "9F12345678DE"};
      vecs[4] = '{1, 48'hFE_DCBA9876_10, 1'b0, "fedcba987610"};
      vecs[5] = '{1, 48'hAB_0000000F_C9, 1'b1, "ab0000000fc9"};

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data", a_out_data, 8'h00);
      check("rst_busy", a_busy, 0);
      check("rst_in_ready", a_in_ready, 0);
      check("rst_in_ready_b", b_in_ready, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("in_ready_after_rst", a_in_ready, 1);
      check("in_ready_after_rst_b", b_in_ready, 1);
      @(posedge clock);
      #1;

      // Table of single records; an overflow pulse while idle marks the line.
      for (int v = 0; v < 6; v++) begin
         if (vecs[v].mark) pulse_ovf(vecs[v].sel);
         push_line(vecs[v].sel, vecs[v].text, vecs[v].mark, 99);
         accept(vecs[v].sel, vecs[v].data, 1'b0, acc);
         drain(vecs[v].sel);
      end

      // Latency: characters on accept+1 .. accept+14, ready again on +15.
      char_cyc0.delete();
      push_line(0, "0200000080A5", 1'b0, 99);
      accept(0, 48'h02_00000080_A5, 1'b0, acc);
      drain(0);
      @(negedge clock);
      check("lat_count", char_cyc0.size(), 14);
      if (char_cyc0.size() == 14) begin
         check("lat_first", char_cyc0[0] - acc, 1);
         check("lat_last", char_cyc0[13] - acc, 14);
      end
      check("ready_cycle", cyc - acc, 15);
      check("ready_again", a_in_ready, 1);
      @(posedge clock);
      #1;

      // Back-pressure: out_ready alternating.
      toggle = 1'b1;
      push_line(0, "0200000080A5", 1'b0, 99);
      accept(0, 48'h02_00000080_A5, 1'b0, acc);
      drain(0);
      toggle = 1'b0;
      @(posedge clock);
      #1;

      // Overflow during emission marks only the next record.
      push_line(0, "9F12345678DE", 1'b0, 99);
      accept(0, 48'h9F_12345678_DE, 1'b0, acc);
      repeat (3) begin @(posedge clock); #1; end
      pulse_ovf(0);
      drain(0);
      push_line(0, "0200000080A5", 1'b1, 99);
      accept(0, 48'h02_00000080_A5, 1'b0, acc);
      drain(0);

      // Reset after 5 characters aborts the line without CR/LF.
      push_line(0, "9F12345678DE", 1'b0, 5);
      accept(0, 48'h9F_12345678_DE, 1'b0, acc);
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(posedge clock);
         #1;
         ok = (q0.size() == 0);
      end
      check("abort_five_chars", ok, 1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("abort_out_valid", a_out_valid, 0);
      check("abort_busy", a_busy, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      push_line(0, "0200000080A5", 1'b0, 99);
      accept(0, 48'h02_00000080_A5, 1'b0, acc);
      drain(0);

      // in_data changes while busy with in_valid held: line unaffected.
      push_line(0, "9F12345678DE", 1'b0, 99);
      push_line(0, "000000FFFF3C", 1'b0, 99);
      accept(0, 48'h9F_12345678_DE, 1'b1, acc);
      accept(0, 48'h00_0000FFFF_3C, 1'b0, acc2);
      check("held_valid_gap", acc2 - acc, 15);
      drain(0);

      check("sb_a_empty", q0.size(), 0);
      check("sb_b_empty", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
